// File: rtl/panda_risc_v_reg_wb_ctrl_pkg.sv
// Shared constants and types for the GPR write-back controller.
package panda_risc_v_reg_wb_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned GPR_NUM    = 32;
  localparam int unsigned GPR_AW     = 5;
  localparam int unsigned WB_REQ_NUM = 3;
  localparam int unsigned WB_IDX_W   = 2;

  typedef logic [WB_IDX_W-1:0] wb_idx_t;
  typedef logic [GPR_AW-1:0]   gpr_addr_t;
  typedef logic [XLEN-1:0]     gpr_data_t;

  localparam wb_idx_t WB_REQ_ALU = 2'd0;
  localparam wb_idx_t WB_REQ_LSU = 2'd1;
  localparam wb_idx_t WB_REQ_MDU = 2'd2;

  typedef struct packed {
    gpr_addr_t rd;
    gpr_data_t data;
  } wb_req_t;

  // Next requester index in rotating order ALU -> LSU -> MDU -> ALU.
  function automatic wb_idx_t rr_next(input wb_idx_t idx);
    return (idx == WB_REQ_MDU) ? WB_REQ_ALU : wb_idx_t'(idx + wb_idx_t'(1));
  endfunction

endpackage

// File: rtl/panda_risc_v_rr_arbiter_3.sv
// Three-way round-robin arbiter; the grant is combinational and the pointer
// moves to the granted requester on every handshake.
module panda_risc_v_rr_arbiter_3
  import panda_risc_v_reg_wb_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [WB_REQ_NUM-1:0] req_valid,
  output logic [WB_REQ_NUM-1:0] grant_c
);

  wb_idx_t last_grant_q;
  wb_idx_t last_grant_d;
  wb_idx_t cand;
  logic    found;

  // Scan starting one past the last winner; a granted requester is always valid.
  always_comb begin
    grant_c      = '0;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    cand         = rr_next(last_grant_q);
    for (int unsigned k = 0; k < WB_REQ_NUM; k++) begin
      if (en && !found && req_valid[cand]) begin
        grant_c[cand] = 1'b1;
        last_grant_d  = cand;
        found         = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

  // Reset value MDU makes ALU the first-priority requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= WB_REQ_MDU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/panda_risc_v_reg_wb_ctrl.sv
// GPR write-back controller: arbitrates ALU/LSU/MDU onto the single write port,
// tracks pending long-latency destinations and bypasses the write to the read ports.
module panda_risc_v_reg_wb_ctrl
  import panda_risc_v_reg_wb_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,

  input  logic              wb_alu_valid,
  input  logic [GPR_AW-1:0] wb_alu_rd,
  input  logic [XLEN-1:0]   wb_alu_data,
  output logic              wb_alu_ready,
  input  logic              wb_lsu_valid,
  input  logic [GPR_AW-1:0] wb_lsu_rd,
  input  logic [XLEN-1:0]   wb_lsu_data,
  output logic              wb_lsu_ready,
  input  logic              wb_mdu_valid,
  input  logic [GPR_AW-1:0] wb_mdu_rd,
  input  logic [XLEN-1:0]   wb_mdu_data,
  output logic              wb_mdu_ready,

  input  logic              lnch_valid,
  input  logic [GPR_AW-1:0] lnch_rd,
  output logic              lnch_ready,

  input  logic [GPR_AW-1:0] rs0_addr,
  input  logic [GPR_AW-1:0] rs1_addr,
  output logic [XLEN-1:0]   rs0_data,
  output logic [XLEN-1:0]   rs1_data,
  output logic              rs0_raw,
  output logic              rs1_raw,
  input  logic [GPR_AW-1:0] waw_rd,
  output logic              waw_hazard,
  output logic              x1_pending,

  output logic              reg_file_wen,
  output logic [GPR_AW-1:0] reg_file_waddr,
  output logic [XLEN-1:0]   reg_file_din,
  output logic [GPR_AW-1:0] reg_file_raddr_p0,
  output logic [GPR_AW-1:0] reg_file_raddr_p1,
  input  logic [XLEN-1:0]   reg_file_dout_p0,
  input  logic [XLEN-1:0]   reg_file_dout_p1
);

  logic [WB_REQ_NUM-1:0] req_valid;
  logic [WB_REQ_NUM-1:0] grant;
  wb_req_t               alu_req;
  wb_req_t               lsu_req;
  wb_req_t               mdu_req;
  wb_req_t               wb_sel;
  logic                  wb_hs;
  logic                  long_hs;
  logic                  lnch_hs;
  logic                  fwd0;
  logic                  fwd1;
  logic [GPR_NUM-1:0]    pending_q;
  logic [GPR_NUM-1:0]    pending_d;

  assign req_valid = {wb_mdu_valid, wb_lsu_valid, wb_alu_valid};
  assign alu_req   = '{rd: wb_alu_rd, data: wb_alu_data};
  assign lsu_req   = '{rd: wb_lsu_rd, data: wb_lsu_data};
  assign mdu_req   = '{rd: wb_mdu_rd, data: wb_mdu_data};

  // Arbiter is disabled in reset so no requester sees ready while resetn is low.
  panda_risc_v_rr_arbiter_3 u_arb (
    .clk       (clk),
    .rst_n     (resetn),
    .en        (resetn),
    .req_valid (req_valid),
    .grant_c   (grant)
  );

  assign wb_alu_ready = grant[WB_REQ_ALU];
  assign wb_lsu_ready = grant[WB_REQ_LSU];
  assign wb_mdu_ready = grant[WB_REQ_MDU];
  assign wb_hs        = |grant;
  assign long_hs      = grant[WB_REQ_LSU] | grant[WB_REQ_MDU];

  always_comb begin
    wb_sel = '0;
    if (grant[WB_REQ_ALU]) begin
      wb_sel = alu_req;
    end else if (grant[WB_REQ_LSU]) begin
      wb_sel = lsu_req;
    end else if (grant[WB_REQ_MDU]) begin
      wb_sel = mdu_req;
    end
  end

  // rd==0 requests are still handshaken, they just never reach the register file.
  assign reg_file_wen      = wb_hs & (wb_sel.rd != '0);
  assign reg_file_waddr    = wb_sel.rd;
  assign reg_file_din      = wb_sel.data;
  assign reg_file_raddr_p0 = rs0_addr;
  assign reg_file_raddr_p1 = rs1_addr;

  assign lnch_ready = resetn & ~pending_q[lnch_rd];
  assign lnch_hs    = lnch_valid & lnch_ready;

  // Clear on long-latency write-back, set on launch; entry 0 stays zero.
  always_comb begin
    pending_d = pending_q;
    if (long_hs) begin
      pending_d[wb_sel.rd] = 1'b0;
    end
    if (lnch_hs) begin
      pending_d[lnch_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign fwd0 = reg_file_wen & (reg_file_waddr == rs0_addr);
  assign fwd1 = reg_file_wen & (reg_file_waddr == rs1_addr);

  // Operand bypass: x0 reads zero, a same-cycle write wins over the stored value.
  always_comb begin
    rs0_data = reg_file_dout_p0;
    rs1_data = reg_file_dout_p1;
    if (rs0_addr == '0) begin
      rs0_data = '0;
    end else if (fwd0) begin
      rs0_data = reg_file_din;
    end
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (fwd1) begin
      rs1_data = reg_file_din;
    end
  end

  assign rs0_raw    = pending_q[rs0_addr] & ~fwd0;
  assign rs1_raw    = pending_q[rs1_addr] & ~fwd1;
  assign waw_hazard = pending_q[waw_rd];
  assign x1_pending = pending_q[1];

endmodule

// File: tb/tb_panda_risc_v_reg_wb_ctrl.sv
// Bench for the GPR write-back controller: arbitration table, directed
// scoreboard/bypass/reset sequences and a randomized run against a model.
module tb_panda_risc_v_reg_wb_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  v;
  logic [4:0]  req_rd  [3];
  logic [31:0] req_dat [3];
  logic        wb_alu_ready, wb_lsu_ready, wb_mdu_ready;
  logic        lnch_valid;
  logic [4:0]  lnch_rd;
  logic        lnch_ready;
  logic [4:0]  rs0_addr, rs1_addr, waw_rd;
  logic [31:0] rs0_data, rs1_data;
  logic        rs0_raw, rs1_raw, waw_hazard, x1_pending;
  logic        reg_file_wen;
  logic [4:0]  reg_file_waddr, reg_file_raddr_p0, reg_file_raddr_p1;
  logic [31:0] reg_file_din, reg_file_dout_p0, reg_file_dout_p1;
  logic [2:0]  rdy;

  always #5 clk = ~clk;

  panda_risc_v_reg_wb_ctrl dut (
    .clk(clk), .resetn(resetn),
    .wb_alu_valid(v[0]), .wb_alu_rd(req_rd[0]), .wb_alu_data(req_dat[0]), .wb_alu_ready(wb_alu_ready),
    .wb_lsu_valid(v[1]), .wb_lsu_rd(req_rd[1]), .wb_lsu_data(req_dat[1]), .wb_lsu_ready(wb_lsu_ready),
    .wb_mdu_valid(v[2]), .wb_mdu_rd(req_rd[2]), .wb_mdu_data(req_dat[2]), .wb_mdu_ready(wb_mdu_ready),
    .lnch_valid(lnch_valid), .lnch_rd(lnch_rd), .lnch_ready(lnch_ready),
    .rs0_addr(rs0_addr), .rs1_addr(rs1_addr), .rs0_data(rs0_data), .rs1_data(rs1_data),
    .rs0_raw(rs0_raw), .rs1_raw(rs1_raw), .waw_rd(waw_rd), .waw_hazard(waw_hazard),
    .x1_pending(x1_pending),
    .reg_file_wen(reg_file_wen), .reg_file_waddr(reg_file_waddr), .reg_file_din(reg_file_din),
    .reg_file_raddr_p0(reg_file_raddr_p0), .reg_file_raddr_p1(reg_file_raddr_p1),
    .reg_file_dout_p0(reg_file_dout_p0), .reg_file_dout_p1(reg_file_dout_p1)
  );

  assign rdy = {wb_mdu_ready, wb_lsu_ready, wb_alu_ready};

  // Physical register file written by the DUT's write port.
  logic [31:0] gpr [32];
  assign reg_file_dout_p0 = gpr[reg_file_raddr_p0];
  assign reg_file_dout_p1 = gpr[reg_file_raddr_p1];
  always @(posedge clk) if (reg_file_wen) gpr[reg_file_waddr] <= reg_file_din;

  // Reference model state.
  int          m_last;
  bit [31:0]   m_pend;
  logic [31:0] ref_gpr [32];
  int          e_g;
  bit          e_wen, e_lacc;
  logic [4:0]  e_wa, e_lrd;
  logic [31:0] e_din;
  int          errors = 0;
  int          checks = 0;
  int          wait_cnt [3];

  typedef struct {
    logic [2:0] v;
    logic [2:0] g;
    logic [4:0] wa;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rs(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (e_wen && e_wa == a) return e_din;
    return ref_gpr[a];
  endfunction

  // Predict this cycle's outputs from the model and compare everything.
  task automatic eval_and_check();
    logic [2:0] exp_rdy;
    e_g = -1;
    if (resetn) begin
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_last + k) % 3;
        if (e_g < 0 && v[i]) e_g = i;
      end
    end
    exp_rdy = '0;
    if (e_g >= 0) exp_rdy[e_g] = 1'b1;
    e_wa   = (e_g >= 0) ? req_rd[e_g] : 5'd0;
    e_din  = (e_g >= 0) ? req_dat[e_g] : 32'd0;
    e_wen  = (e_g >= 0) && (e_wa != 5'd0);
    e_lacc = resetn && !m_pend[lnch_rd];
    e_lrd  = lnch_rd;
    chk("ready", 32'(rdy), 32'(exp_rdy));
    chk("lnch_ready", 32'(lnch_ready), 32'(e_lacc));
    chk("wen", 32'(reg_file_wen), 32'(e_wen));
    if (e_wen) begin
      chk("waddr", 32'(reg_file_waddr), 32'(e_wa));
      chk("din", reg_file_din, e_din);
    end
    chk("raddr_p0", 32'(reg_file_raddr_p0), 32'(rs0_addr));
    chk("rs0_data", rs0_data, exp_rs(rs0_addr));
    chk("rs1_data", rs1_data, exp_rs(rs1_addr));
    chk("rs0_raw", 32'(rs0_raw), 32'(m_pend[rs0_addr] && !(e_wen && e_wa == rs0_addr)));
    chk("rs1_raw", 32'(rs1_raw), 32'(m_pend[rs1_addr] && !(e_wen && e_wa == rs1_addr)));
    chk("waw_hazard", 32'(waw_hazard), 32'(m_pend[waw_rd]));
    chk("x1_pending", 32'(x1_pending), 32'(m_pend[1]));
  endtask

  task automatic commit();
    if (!resetn) begin
      m_pend = '0;
      m_last = 2;
      return;
    end
    if (e_g >= 0) begin
      m_last = e_g;
      if (e_g > 0) m_pend[e_wa] = 1'b0;
    end
    if (e_wen) ref_gpr[e_wa] = e_din;
    if (lnch_valid && e_lacc && e_lrd != 5'd0) m_pend[e_lrd] = 1'b1;
    m_pend[0] = 1'b0;
  endtask

  task automatic settle();
    #2;
    eval_and_check();
  endtask

  task automatic advance();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic set_req(input int i, input logic vv, input logic [4:0] r, input logic [31:0] d);
    v[i] = vv;
    req_rd[i] = r;
    req_dat[i] = d;
  endtask

  initial begin
    tbl[0]  = '{3'b111, 3'b001, 5'd5};
    tbl[1]  = '{3'b111, 3'b010, 5'd6};
    tbl[2]  = '{3'b111, 3'b100, 5'd7};
    tbl[3]  = '{3'b110, 3'b010, 5'd6};
    tbl[4]  = '{3'b011, 3'b001, 5'd5};
    tbl[5]  = '{3'b101, 3'b100, 5'd7};
    tbl[6]  = '{3'b000, 3'b000, 5'd0};
    tbl[7]  = '{3'b010, 3'b010, 5'd6};
    tbl[8]  = '{3'b001, 3'b001, 5'd5};
    tbl[9]  = '{3'b100, 3'b100, 5'd7};
    tbl[10] = '{3'b011, 3'b001, 5'd5};
    tbl[11] = '{3'b110, 3'b010, 5'd6};
    tbl[12] = '{3'b111, 3'b100, 5'd7};
    tbl[13] = '{3'b111, 3'b001, 5'd5};

    for (int r = 0; r < 32; r++) begin
      gpr[r]     = 32'hA000_0000 + 32'(r);
      ref_gpr[r] = 32'hA000_0000 + 32'(r);
    end
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    m_pend = '0;
    m_last = 2;

    // Reset with every request asserted: nothing may be accepted.
    resetn = 1'b0;
    set_req(0, 1'b1, 5'd5, 32'h1111_0005);
    set_req(1, 1'b1, 5'd6, 32'h2222_0006);
    set_req(2, 1'b1, 5'd7, 32'h3333_0007);
    lnch_valid = 1'b1; lnch_rd = 5'd4;
    rs0_addr = 5'd5; rs1_addr = 5'd6; waw_rd = 5'd4;
    #1;
    settle(); advance();
    settle(); advance();
    resetn = 1'b1;
    lnch_valid = 1'b0;

    // Arbitration table.
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < 3; i++) begin
        v[i] = tbl[t].v[i];
        req_dat[i] = 32'h5000_0000 + 32'(t * 16 + i);
      end
      settle();
      chk("tbl_grant", 32'(rdy), 32'(tbl[t].g));
      if (tbl[t].g != 3'b000) chk("tbl_waddr", 32'(reg_file_waddr), 32'(tbl[t].wa));
      advance();
    end
    v = 3'b000;

    // Launch x9, observe RAW/WAW, then LSU write-back with bypass.
    lnch_valid = 1'b1; lnch_rd = 5'd9;
    settle(); chk("lnch9_ready", 32'(lnch_ready), 32'd1); advance();
    rs0_addr = 5'd9; waw_rd = 5'd9;
    settle();
    chk("lnch9_again_ready", 32'(lnch_ready), 32'd0);
    chk("rs0_raw_9", 32'(rs0_raw), 32'd1);
    chk("waw_9", 32'(waw_hazard), 32'd1);
    advance();
    lnch_rd = 5'd1;
    settle(); chk("lnch1_ready", 32'(lnch_ready), 32'd1); advance();
    lnch_valid = 1'b0;
    settle(); chk("x1_pending_set", 32'(x1_pending), 32'd1); advance();
    set_req(1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    settle();
    chk("lsu9_ready", 32'(wb_lsu_ready), 32'd1);
    chk("rs0_raw_wb", 32'(rs0_raw), 32'd0);
    chk("rs0_bypass", rs0_data, 32'hDEAD_BEEF);
    chk("waw_wb_cycle", 32'(waw_hazard), 32'd1);
    advance();
    v[1] = 1'b0;
    settle();
    chk("waw_9_cleared", 32'(waw_hazard), 32'd0);
    chk("rs0_after_wb", rs0_data, 32'hDEAD_BEEF);
    advance();
    set_req(2, 1'b1, 5'd1, 32'h0000_0ABC);
    settle(); advance();
    v[2] = 1'b0;
    settle(); chk("x1_pending_clr", 32'(x1_pending), 32'd0); advance();

    // ALU write to x0: accepted, no write, x0 reads zero.
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    rs0_addr = 5'd0;
    settle();
    chk("x0_ready", 32'(wb_alu_ready), 32'd1);
    chk("x0_wen", 32'(reg_file_wen), 32'd0);
    chk("x0_read", rs0_data, 32'd0);
    advance();
    v[0] = 1'b0;

    // Reset in the middle of operation.
    lnch_valid = 1'b1; lnch_rd = 5'd3;
    settle(); advance();
    lnch_valid = 1'b0; waw_rd = 5'd3;
    settle(); chk("waw_3_pre", 32'(waw_hazard), 32'd1); advance();
    set_req(0, 1'b1, 5'd5, 32'h0101_0101);
    set_req(1, 1'b1, 5'd6, 32'h0202_0202);
    set_req(2, 1'b1, 5'd7, 32'h0303_0303);
    lnch_valid = 1'b1; lnch_rd = 5'd4;
    #1;
    resetn = 1'b0;
    m_pend = '0;
    m_last = 2;
    settle();
    chk("rst_waw", 32'(waw_hazard), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_lnch", 32'(lnch_ready), 32'd0);
    chk("rst_wen", 32'(reg_file_wen), 32'd0);
    advance();
    resetn = 1'b1;
    lnch_valid = 1'b0;
    settle(); chk("post_rst_alu", 32'(rdy), 32'b001); advance();
    v = 3'b000;

    // Randomized legal traffic against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          logic [4:0] pick;
          int cnt;
          pick = 5'd0;
          cnt = 0;
          if (i == 0) begin
            pick = 5'($urandom_range(0, 31));
            if (m_pend[pick]) pick = 5'd0;
          end else begin
            for (int r = 1; r < 32; r++) begin
              if (m_pend[r] && !(v[1] && req_rd[1] == 5'(r)) && !(v[2] && req_rd[2] == 5'(r))) begin
                cnt++;
                if ($urandom_range(1, cnt) == 1) pick = 5'(r);
              end
            end
          end
          set_req(i, 1'b1, pick, $urandom);
        end
      end
      lnch_rd = 5'($urandom_range(0, 31));
      lnch_valid = 1'($urandom_range(0, 1));
      if ((v[1] && lnch_rd == req_rd[1]) || (v[2] && lnch_rd == req_rd[2])) lnch_valid = 1'b0;
      rs0_addr = ($urandom_range(0, 3) == 0) ? req_rd[$urandom_range(0, 2)] : 5'($urandom_range(0, 31));
      rs1_addr = 5'($urandom_range(0, 31));
      waw_rd   = 5'($urandom_range(0, 31));
      settle();
      for (int i = 0; i < 3; i++) begin
        if (v[i] && !rdy[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        chk("starve", 32'(wait_cnt[i] > 2), 32'd0);
      end
      advance();
      if (e_g >= 0) v[e_g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
